// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// | Module   : uart_tx_arbiter_pkg                                          |
// | Brief    : Shared byte type and arbiter FSM state encoding.             |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

package uart_tx_arbiter_pkg;

  typedef logic [7:0] w8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_RISE = 2'd2,
    S_WAIT_FALL = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_tx_req_fifo.sv
// ---------------------------------------------------------------------------
// | Module   : tx_req_fifo                                                  |
// | Brief    : Single-requester byte FIFO with sticky drop flag.            |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module tx_req_fifo
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  w8                      din,
  output w8                      head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   overflow
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  typedef logic [c_PTR_W-1:0] ptr_t;

  w8                  r_mem [DEPTH];
  ptr_t               r_wr_ptr;
  ptr_t               r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;
  logic               w_full;
  logic               w_pop_ok;
  logic               w_push_ok;

  assign w_full    = (r_count == c_CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_pop_ok  = pop && !empty;
  // A full FIFO still accepts a byte when its head leaves in the same cycle.
  assign w_push_ok = push && (!w_full || w_pop_ok);

  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign head     = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// | Module   : uart_tx_arbiter                                              |
// | Brief    : Round-robin sharing of one UartTx among N_REQ byte senders.  |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_en,
  input  logic [N_REQ*8-1:0] req_data,
  output logic [N_REQ-1:0]   req_busy,
  output logic [N_REQ-1:0]   overflow,
  output logic               tx_start,
  output logic [7:0]         sdata,
  input  logic               tx_busy
);

  localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  arb_state_e         r_state;
  arb_state_e         w_state_next;
  logic [c_IDX_W-1:0] r_rr_ptr;
  w8                  r_sdata;

  w8                  w_head  [N_REQ];
  logic [c_CNT_W-1:0] w_count [N_REQ];
  logic [N_REQ-1:0]   w_empty;
  logic [N_REQ-1:0]   w_pop;
  logic               w_any_ready;
  logic [c_IDX_W-1:0] w_winner;
  logic               w_grant;

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
      tx_req_fifo #(
        .DEPTH (DEPTH)
      ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (req_en[i]),
        .pop      (w_pop[i]),
        .din      (req_data[8*i +: 8]),
        .head     (w_head[i]),
        .count    (w_count[i]),
        .empty    (w_empty[i]),
        .overflow (overflow[i])
      );

      assign req_busy[i] = (w_count[i] == c_CNT_W'(DEPTH));
      assign w_pop[i]    = w_grant && (w_winner == c_IDX_W'(i));
    end
  endgenerate

  // Scan starts just after the last winner so every requester gets a turn.
  always_comb begin
    logic [c_IDX_W-1:0] v_idx;
    w_any_ready = 1'b0;
    w_winner    = '0;
    v_idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      v_idx = c_IDX_W'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_any_ready && !w_empty[v_idx]) begin
        w_any_ready = 1'b1;
        w_winner    = v_idx;
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && !tx_busy && w_any_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= c_IDX_W'(N_REQ - 1);
      r_sdata  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_rr_ptr <= w_winner;
        r_sdata  <= w_head[w_winner];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_grant) w_state_next = S_START;
      S_START:     w_state_next = S_WAIT_RISE;
      S_WAIT_RISE: if (tx_busy) w_state_next = S_WAIT_FALL;
      S_WAIT_FALL: if (!tx_busy) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  assign tx_start = (r_state == S_START);
  assign sdata    = r_sdata;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// | Module   : tb_uart_tx_arbiter                                           |
// | Brief    : Directed self-checking bench with a simple UartTx model.     |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_en = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_busy;
  logic [1:0]  overflow;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        tx_busy;
  logic        hold_busy = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  log_q[$];
  int          bad_start = 0;
  int          busy_cnt = 0;

  uart_tx_arbiter #(
    .N_REQ (2),
    .DEPTH (4)
  ) dut (
    .clock    (clk),
    .reset    (reset),
    .req_en   (req_en),
    .req_data (req_data),
    .req_busy (req_busy),
    .overflow (overflow),
    .tx_start (tx_start),
    .sdata    (sdata),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  // UartTx model: busy rises one cycle after start and lasts 20 cycles.
  assign tx_busy = hold_busy | (busy_cnt > 0 && busy_cnt <= 20);

  always @(posedge clk) begin
    if (tx_start) begin
      log_q.push_back(sdata);
      if (busy_cnt != 0 || hold_busy) bad_start <= bad_start + 1;
    end
    if (tx_start && busy_cnt == 0) busy_cnt <= 21;
    else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 8'hxx;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_en    = '0;
    hold_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    log_q.delete();
  endtask

  task automatic push(input int r, input logic [7:0] b);
    req_en[r]          = 1'b1;
    req_data[8*r +: 8] = b;
    @(negedge clk);
    req_en = '0;
  endtask

  task automatic wait_bytes(input int n, input string name);
    int budget = 2000;
    while (log_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (log_q.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d bytes, required %0d", name, log_q.size(), n);
    end
    repeat (60) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b required 0", tx_start); end
    checks++; if (sdata !== 8'h00) begin errors++; $display("FAIL reset_sdata: got %h required 00", sdata); end
    checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL reset_overflow: got %b required 00", overflow); end
    checks++; if (req_busy !== 2'b00) begin errors++; $display("FAIL reset_req_busy: got %b required 00", req_busy); end
  endtask

  task automatic test_single();
    int bad0;
    do_reset();
    bad0 = bad_start;
    push(0, 8'hA5);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_early_start: got %b required 0", tx_start); end
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start_latency: got %b required 1", tx_start); end
    checks++; if (sdata !== 8'hA5) begin errors++; $display("FAIL single_sdata: got %h required a5", sdata); end
    repeat (40) @(negedge clk);
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL single_start_count: got %0d required 1", log_q.size()); end
    checks++; if (bad_start != bad0) begin errors++; $display("FAIL single_start_while_busy: got %0d required %0d", bad_start, bad0); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    req_en   = 2'b11;
    req_data = 16'h2211;
    @(negedge clk);
    req_en = '0;
    wait_bytes(2, "same_cycle");
    checks++; if (log_at(0) !== 8'h11) begin errors++; $display("FAIL same_cycle_byte0: got %h required 11", log_at(0)); end
    checks++; if (log_at(1) !== 8'h22) begin errors++; $display("FAIL same_cycle_byte1: got %h required 22", log_at(1)); end
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL same_cycle_count: got %0d required 2", log_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_b [6];
    exp_b = '{8'h01, 8'h81, 8'h02, 8'h82, 8'h03, 8'h83};
    do_reset();
    hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_en   = 2'b11;
      req_data = {8'(8'h81 + i), 8'(8'h01 + i)};
      @(negedge clk);
    end
    req_en    = '0;
    hold_busy = 1'b0;
    wait_bytes(6, "round_robin");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_at(i) !== exp_b[i]) begin
        errors++;
        $display("FAIL round_robin_byte%0d: got %h required %h", i, log_at(i), exp_b[i]);
      end
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(1, 8'(8'hA0 + i));
      if (i == 2) begin
        checks++; if (req_busy[1] !== 1'b0) begin errors++; $display("FAIL full_busy_after3: got %b required 0", req_busy[1]); end
      end
      if (i == 3) begin
        checks++; if (req_busy[1] !== 1'b1) begin errors++; $display("FAIL full_busy_after4: got %b required 1", req_busy[1]); end
        checks++; if (overflow[1] !== 1'b0) begin errors++; $display("FAIL full_ovf_after4: got %b required 0", overflow[1]); end
      end
      if (i == 4) begin
        checks++; if (overflow[1] !== 1'b1) begin errors++; $display("FAIL full_ovf_after5: got %b required 1", overflow[1]); end
      end
    end
    hold_busy = 1'b0;
    wait_bytes(4, "full_drain");
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL full_drain_count: got %0d required 4", log_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_at(i) !== 8'(8'hA0 + i)) begin
        errors++;
        $display("FAIL full_drain_byte%0d: got %h required %h", i, log_at(i), 8'(8'hA0 + i));
      end
    end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(0, 8'(8'h50 + i));
    checks++; if (req_busy[0] !== 1'b1) begin errors++; $display("FAIL poppush_full: got %b required 1", req_busy[0]); end
    hold_busy    = 1'b0;
    req_en[0]    = 1'b1;
    req_data[7:0] = 8'h55;
    @(negedge clk);
    req_en = '0;
    checks++; if (overflow[0] !== 1'b0) begin errors++; $display("FAIL poppush_overflow: got %b required 0", overflow[0]); end
    checks++; if (req_busy[0] !== 1'b1) begin errors++; $display("FAIL popush_count_kept: got %b required 1", req_busy[0]); end
    checks++; if (tx_start !== 1'b1 || sdata !== 8'h50) begin errors++; $display("FAIL popush_grant: got start=%b sdata=%h required start=1 sdata=50", tx_start, sdata); end
    wait_bytes(5, "popush_drain");
    checks++; if (log_at(4) !== 8'h55) begin errors++; $display("FAIL popush_last: got %h required 55", log_at(4)); end
  endtask

  task automatic test_reset_mid();
    int n0;
    int budget;
    int bad0;
    do_reset();
    bad0 = bad_start;
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(0, 8'(8'h60 + i));
    checks++; if (overflow[0] !== 1'b1) begin errors++; $display("FAIL mid_setup_overflow: got %b required 1", overflow[0]); end
    hold_busy = 1'b0;
    budget = 200;
    while ((log_q.size() < 1 || tx_busy !== 1'b1) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++; if (budget == 0) begin errors++; $display("FAIL mid_reach_wait_fall: got timeout required busy phase"); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_tx_start: got %b required 0", tx_start); end
    checks++; if (req_busy !== 2'b00) begin errors++; $display("FAIL mid_req_busy: got %b required 00", req_busy); end
    checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL mid_overflow: got %b required 00", overflow); end
    reset = 1'b0;
    n0 = log_q.size();
    repeat (60) @(negedge clk);
    checks++; if (log_q.size() != n0) begin errors++; $display("FAIL mid_no_restart: got %0d starts required %0d", log_q.size(), n0); end
    push(1, 8'h77);
    wait_bytes(n0 + 1, "mid_new_push");
    checks++; if (log_at(n0) !== 8'h77) begin errors++; $display("FAIL mid_new_byte: got %h required 77", log_at(n0)); end
    checks++; if (bad_start != bad0) begin errors++; $display("FAIL mid_start_while_busy: got %0d required %0d", bad_start, bad0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_round_robin();
    test_full_overflow();
    test_full_pop_push();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
